// File: rtl/ip_sync_multi_if.sv
// Avalon-MM request/response bundle shared by the slave (upstream) and master (downstream) sides
// of the trigger snooper.
interface ip_sync_multi_if;
    logic        r;
    logic        w;
    logic [31:0] wdata;
    logic [7:0]  addr;
    logic [7:0]  burstcount;
    logic [3:0]  byteenable;
    logic [31:0] rdata;
    logic        readdatavalid;
    logic        waitrequest;

    modport master (
        output r, w, wdata, addr, burstcount, byteenable,
        input  rdata, readdatavalid, waitrequest
    );

    modport slave (
        input  r, w, wdata, addr, burstcount, byteenable,
        output rdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/ip_sync_multi.sv
// Inline AVMM snooper: passes the bus through untouched and turns accepted trigger writes into
// timestamped bitmap beats on an AVST source, either sampled every cycle or FIFO-buffered.
module ip_sync_multi #(
    parameter int          NUM_TRIG     = 4,
    parameter logic [7:0]  ADDR_BASE    = 8'h8,
    parameter logic [7:0]  ADDR_CTRL    = 8'h4,
    parameter logic [31:0] DATA_TRIGGER = 32'd2,
    parameter int          MODE         = 1,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          TS_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    ip_sync_multi_if.slave        s_avmm,
    ip_sync_multi_if.master       m_avmm,
    input  logic                  M_AVST_READY,
    output logic [TS_WIDTH+7:0]   M_AVST_DATA,
    output logic                  M_AVST_VALID,
    output logic                  OVERFLOW,
    output logic [7:0]            DROP_COUNT
);
    localparam int DW = TS_WIDTH + 8;

    assign m_avmm.r          = s_avmm.r;
    assign m_avmm.w          = s_avmm.w;
    assign m_avmm.wdata      = s_avmm.wdata;
    assign m_avmm.addr       = s_avmm.addr;
    assign m_avmm.burstcount = s_avmm.burstcount;
    assign m_avmm.byteenable = s_avmm.byteenable;
    assign s_avmm.rdata         = m_avmm.rdata;
    assign s_avmm.readdatavalid = m_avmm.readdatavalid;
    assign s_avmm.waitrequest   = m_avmm.waitrequest;

    logic                acc;
    logic [7:0]          hit;
    logic [NUM_TRIG-1:0] en;
    logic [TS_WIDTH-1:0] ts;

    // Only writes the downstream slave actually takes count; stalled writes are retried later.
    assign acc = s_avmm.w & ~m_avmm.waitrequest;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (acc && (s_avmm.addr == ADDR_BASE + 8'(i)) &&
                (s_avmm.wdata == DATA_TRIGGER) && en[i]) begin
                hit[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            en <= '1;
            ts <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (acc && (s_avmm.addr == ADDR_CTRL)) begin
                en <= s_avmm.wdata[NUM_TRIG-1:0];
            end
        end
    end

    generate
        if (MODE == 0) begin : g_stream
            logic unused_ready;
            assign unused_ready = M_AVST_READY;
            assign OVERFLOW     = 1'b0;
            assign DROP_COUNT   = 8'd0;

            always_ff @(posedge clk) begin
                if (reset) begin
                    M_AVST_DATA  <= '0;
                    M_AVST_VALID <= 1'b0;
                end else begin
                    M_AVST_DATA  <= {ts, hit};
                    M_AVST_VALID <= 1'b1;
                end
            end
        end else begin : g_event
            localparam int AW = $clog2(FIFO_DEPTH);

            logic [DW-1:0] mem [FIFO_DEPTH];
            logic [AW:0]   wr_ptr;
            logic [AW:0]   rd_ptr;
            logic          empty;
            logic          full;
            logic          push;
            logic          pop;
            logic          do_push;
            logic          drop;
            logic          ovf;
            logic [7:0]    drop_cnt;

            assign empty   = (wr_ptr == rd_ptr);
            assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
            assign push    = |hit;
            assign pop     = ~empty & M_AVST_READY;
            // A pop frees the head slot in the same edge, so a full FIFO can still accept.
            assign do_push = push & (~full | pop);
            assign drop    = push & full & ~pop;

            always_ff @(posedge clk) begin
                if (do_push) begin
                    mem[wr_ptr[AW-1:0]] <= {ts, hit};
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    ovf      <= 1'b0;
                    drop_cnt <= 8'd0;
                end else begin
                    if (do_push) wr_ptr <= wr_ptr + 1'b1;
                    if (pop)     rd_ptr <= rd_ptr + 1'b1;
                    if (drop) begin
                        ovf <= 1'b1;
                        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
                    end
                end
            end

            // Head comes straight from the flop array; masked to zero whenever nothing is queued.
            assign M_AVST_VALID = ~empty;
            assign M_AVST_DATA  = empty ? '0 : mem[rd_ptr[AW-1:0]];
            assign OVERFLOW     = ovf;
            assign DROP_COUNT   = drop_cnt;
        end
    endgenerate
endmodule

// File: tb/tb_ip_sync_multi.sv
// Bench for ip_sync_multi: a stream-mode and an event-mode instance see the same AVMM traffic;
// expected beats are queued at stimulus time and popped by a negedge monitor.
module tb_ip_sync_multi;
    localparam int DW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        s_r = 1'b0, s_w = 1'b0;
    logic [31:0] s_wdata = '0;
    logic [7:0]  s_addr = '0, s_burst = 8'd1;
    logic [3:0]  s_be = 4'hF;
    logic [31:0] m_rdata = '0;
    logic        m_rdv = 1'b0, m_wreq = 1'b0, ready = 1'b0;

    ip_sync_multi_if s_if0 (), m_if0 (), s_if1 (), m_if1 ();

    assign s_if0.r = s_r;           assign s_if1.r = s_r;
    assign s_if0.w = s_w;           assign s_if1.w = s_w;
    assign s_if0.wdata = s_wdata;   assign s_if1.wdata = s_wdata;
    assign s_if0.addr = s_addr;     assign s_if1.addr = s_addr;
    assign s_if0.burstcount = s_burst;  assign s_if1.burstcount = s_burst;
    assign s_if0.byteenable = s_be;     assign s_if1.byteenable = s_be;
    assign m_if0.rdata = m_rdata;       assign m_if1.rdata = m_rdata;
    assign m_if0.readdatavalid = m_rdv; assign m_if1.readdatavalid = m_rdv;
    assign m_if0.waitrequest = m_wreq;  assign m_if1.waitrequest = m_wreq;

    logic [DW-1:0] str_data, evt_data;
    logic          str_valid, evt_valid, str_ovf, evt_ovf;
    logic [7:0]    str_drop, evt_drop;

    ip_sync_multi #(.MODE(0)) u_str (
        .clk(clk), .reset(rst), .s_avmm(s_if0), .m_avmm(m_if0), .M_AVST_READY(ready),
        .M_AVST_DATA(str_data), .M_AVST_VALID(str_valid), .OVERFLOW(str_ovf), .DROP_COUNT(str_drop)
    );

    ip_sync_multi #(.MODE(1)) u_evt (
        .clk(clk), .reset(rst), .s_avmm(s_if1), .m_avmm(m_if1), .M_AVST_READY(ready),
        .M_AVST_DATA(evt_data), .M_AVST_VALID(evt_valid), .OVERFLOW(evt_ovf), .DROP_COUNT(evt_drop)
    );

    // Scoreboard state
    logic [DW-1:0] exp_q[$];
    int            compared = 0;
    int            mismatched = 0;
    int            beat_cnt = 0;
    logic [15:0]   ts_model = '0;
    logic [7:0]    cur_bm = '0;
    logic [3:0]    en_m = 4'hF;
    logic          ovf_pend = 1'b0, exp_ovf = 1'b0;
    logic [7:0]    drop_pend = '0, exp_drop = '0;
    logic [DW-1:0] str_exp = '0;
    logic          str_exp_vld = 1'b0;
    logic          rst_q = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) begin
            ts_model    <= '0;
            str_exp_vld <= 1'b0;
            exp_ovf     <= 1'b0;
            exp_drop    <= '0;
        end else begin
            ts_model    <= ts_model + 16'd1;
            str_exp     <= {ts_model, cur_bm};
            str_exp_vld <= 1'b1;
            exp_ovf     <= ovf_pend;
            exp_drop    <= drop_pend;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (rst_q) begin
            check("rst_evt_valid", evt_valid, 0);
            check("rst_evt_data", evt_data, 0);
            check("rst_evt_err", {evt_ovf, evt_drop}, 0);
            check("rst_str_out", {str_valid, str_data}, 0);
        end else begin
            check("avmm_req", {m_if1.r, m_if1.w, m_if1.addr, m_if1.burstcount, m_if1.byteenable},
                  {s_r, s_w, s_addr, s_burst, s_be});
            check("avmm_wdata", m_if1.wdata, s_wdata);
            check("avmm_rsp", {s_if1.readdatavalid, s_if1.waitrequest}, {m_rdv, m_wreq});
            check("avmm_rdata", s_if1.rdata, m_rdata);
            check("avmm_req_str", {m_if0.w, m_if0.addr, m_if0.wdata[7:0]},
                  {s_w, s_addr, s_wdata[7:0]});
            if (str_exp_vld) begin
                check("str_valid", str_valid, 1);
                check("str_data", str_data, str_exp);
            end
            check("str_err", {str_ovf, str_drop}, 0);
            check("evt_ovf", evt_ovf, exp_ovf);
            check("evt_drop", evt_drop, exp_drop);
            if (evt_valid && ready) begin
                beat_cnt++;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL evt_extra: got beat %h expected none", evt_data);
                end else begin
                    check("evt_data", evt_data, exp_q.pop_front());
                end
            end
        end
    end

    // Driver: one cycle of inputs plus the expected trigger outcome
    task automatic step(input logic w, input logic [7:0] a, input logic [31:0] d,
                        input logic wreq, input logic rdy);
        logic [7:0] bm;
        logic       acc;
        @(posedge clk); #1;
        s_w = w; s_addr = a; s_wdata = d; m_wreq = wreq; ready = rdy;
        s_r = 1'($urandom_range(0, 1));
        s_be = 4'($urandom_range(0, 15));
        s_burst = 8'($urandom_range(1, 4));
        m_rdata = $urandom;
        m_rdv = 1'($urandom_range(0, 1));
        bm = '0;
        acc = w & ~wreq;
        if (acc && d == 32'd2 && a >= 8'h08 && a <= 8'h0B && en_m[a[1:0]]) bm[a[1:0]] = 1'b1;
        if (acc && a == 8'h04) en_m = d[3:0];
        cur_bm = bm;
        if (bm != 8'd0) begin
            if (exp_q.size() >= 8 && !rdy) begin
                ovf_pend = 1'b1;
                if (drop_pend != 8'hFF) drop_pend = drop_pend + 8'd1;
            end else begin
                exp_q.push_back({ts_model, bm});
            end
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 32'h0, 1'b0, rdy);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1; ready = 1'b0; s_w = 1'b0; m_wreq = 1'b0; cur_bm = '0;
        exp_q.delete();
        en_m = 4'hF; ovf_pend = 1'b0; drop_pend = '0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int cnt0;

    initial begin
        do_reset(2);
        // Stream: write in cycle 10, bitmap visible in cycle 11 with ts 10
        idle(9, 1'b1);
        step(1'b1, 8'h09, 32'd2, 1'b0, 1'b1);
        idle(1, 1'b1);
        @(negedge clk);
        check("stream_cycle11", str_data, 24'h000A02);

        // Event ordering, back to back
        step(1'b1, 8'h08, 32'd2, 1'b0, 1'b1);
        step(1'b1, 8'h0A, 32'd2, 1'b0, 1'b1);
        step(1'b1, 8'h0B, 32'd2, 1'b0, 1'b1);
        idle(4, 1'b1);
        check("order_drained", exp_q.size(), 0);

        // Gating: disabled channel, wrong data, stalled write
        step(1'b1, 8'h04, 32'h0, 1'b0, 1'b1);
        step(1'b1, 8'h08, 32'd2, 1'b0, 1'b1);
        step(1'b1, 8'h04, 32'hF, 1'b0, 1'b1);
        step(1'b1, 8'h08, 32'd3, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 8'h08, 32'd2, 1'b1, 1'b1);
        step(1'b1, 8'h08, 32'd2, 1'b0, 1'b1);
        idle(3, 1'b1);
        @(negedge clk);
        check("gate_valid_low", evt_valid, 0);
        check("gate_drained", exp_q.size(), 0);

        // Overflow: 10 hits into a stalled sink
        for (int i = 0; i < 10; i++) step(1'b1, 8'h08 + 8'(i % 4), 32'd2, 1'b0, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        check("ovf_flag", evt_ovf, 1);
        check("ovf_drop2", evt_drop, 8'd2);
        check("ovf_valid", evt_valid, 1);
        idle(10, 1'b1);
        @(negedge clk);
        check("ovf_drain_valid", evt_valid, 0);
        check("ovf_drained", exp_q.size(), 0);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) step(1'b1, 8'h08 + 8'(i % 4), 32'd2, 1'b0, 1'b0);
        step(1'b1, 8'h0B, 32'd2, 1'b0, 1'b1);
        idle(1, 1'b0);
        @(negedge clk);
        check("pp_no_drop", evt_drop, 8'd2);
        cnt0 = beat_cnt;
        idle(10, 1'b1);
        @(negedge clk);
        check("pp_occupancy8", beat_cnt - cnt0, 8);
        check("pp_drained", exp_q.size(), 0);

        // Reset with 5 queued and channels disabled
        for (int i = 0; i < 5; i++) step(1'b1, 8'h09, 32'd2, 1'b0, 1'b0);
        step(1'b1, 8'h04, 32'h0, 1'b0, 1'b0);
        do_reset(1);
        idle(1, 1'b1);
        step(1'b1, 8'h08, 32'd2, 1'b0, 1'b1);
        idle(1, 1'b1);
        @(negedge clk);
        check("post_rst_valid", evt_valid, 1);
        check("post_rst_data", evt_data, 24'h000201);
        idle(3, 1'b1);
        check("final_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
